// File: rtl/branch_pred_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// branch_pred_unit : branch resolve, bimodal BHT predictor, perf counters
// Revision: 1.0
// ---------------------------------------------------------------------------
module branch_pred_unit #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int PERF_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [2:0]        ex_branch,
  input  logic              ex_less,
  input  logic              ex_zero,
  input  logic              ex_pred_taken,
  output logic              pc_src_a,
  output logic              pc_src_b,
  output logic              mispredict,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispred
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [1:0]        bht_entry_d;
  logic [PERF_W-1:0] perf_br_q, perf_br_d;
  logic [PERF_W-1:0] perf_mp_q, perf_mp_d;

  logic [IDX_W-1:0]  w_if_idx;
  logic [IDX_W-1:0]  w_ex_idx;
  logic              w_taken;
  logic              w_update;
  logic              w_unused_pc;

  assign w_if_idx    = if_pc[IDX_W+1:2];
  assign w_ex_idx    = ex_pc[IDX_W+1:2];
  // Only the index bits of the PCs matter; fold the rest away.
  assign w_unused_pc = ^{if_pc, ex_pc};

  always_comb begin
    w_taken = 1'b0;
    case (ex_branch[1:0])
      2'b00:   w_taken = ex_zero;
      2'b01:   w_taken = ~ex_zero;
      2'b10:   w_taken = ex_less;
      default: w_taken = ~ex_less;
    endcase
  end

  assign w_update      = ex_valid & ex_branch[2];
  assign pc_src_a      = ex_valid & ((ex_branch == 3'b001) | (ex_branch == 3'b010) |
                                     (ex_branch[2] & w_taken));
  assign pc_src_b      = ex_valid & (ex_branch == 3'b010);
  assign mispredict    = w_update & (w_taken != ex_pred_taken);
  assign if_pred_taken = bht_q[w_if_idx][1];
  assign perf_branches = perf_br_q;
  assign perf_mispred  = perf_mp_q;

  always_comb begin
    bht_entry_d = bht_q[w_ex_idx];
    if (w_taken && bht_q[w_ex_idx] != 2'b11) begin
      bht_entry_d = bht_q[w_ex_idx] + 2'b01;
    end else if (!w_taken && bht_q[w_ex_idx] != 2'b00) begin
      bht_entry_d = bht_q[w_ex_idx] - 2'b01;
    end
  end

  always_comb begin
    perf_br_d = perf_br_q;
    perf_mp_d = perf_mp_q;
    if (w_update && perf_br_q != {PERF_W{1'b1}}) begin
      perf_br_d = perf_br_q + PERF_W'(1);
    end
    if (mispredict && perf_mp_q != {PERF_W{1'b1}}) begin
      perf_mp_d = perf_mp_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= 2'b01;
      end
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      if (w_update) begin
        bht_q[w_ex_idx] <= bht_entry_d;
      end
      perf_br_q <= perf_br_d;
      perf_mp_q <= perf_mp_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_pred_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_branch_pred_unit : vector table, directed corner cases, random vs model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_branch_pred_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [2:0]  ex_branch;
  logic        ex_less, ex_zero, ex_pred_taken;

  logic        pred, src_a, src_b, mis;
  logic [31:0] perf_b, perf_m;
  logic        pred4, src_a4, src_b4, mis4;
  logic [3:0]  perf_b4, perf_m4;

  always #5 clk = ~clk;

  branch_pred_unit dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(pred),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch),
    .ex_less(ex_less), .ex_zero(ex_zero), .ex_pred_taken(ex_pred_taken),
    .pc_src_a(src_a), .pc_src_b(src_b), .mispredict(mis),
    .perf_branches(perf_b), .perf_mispred(perf_m)
  );

  branch_pred_unit #(.PERF_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(pred4),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch(ex_branch),
    .ex_less(ex_less), .ex_zero(ex_zero), .ex_pred_taken(ex_pred_taken),
    .pc_src_a(src_a4), .pc_src_b(src_b4), .mispredict(mis4),
    .perf_branches(perf_b4), .perf_mispred(perf_m4)
  );

  // Reference model: per-entry counter as an integer 0..3, unbounded event counts.
  int     m_bht [64];
  longint m_branches, m_mispred;
  int     n_cmp = 0;
  int     n_err = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  function automatic bit is_cond(input logic [2:0] code);
    return code inside {3'b100, 3'b101, 3'b110, 3'b111};
  endfunction

  function automatic bit outcome(input logic [2:0] code, input bit z, input bit l);
    case (code)
      3'b100:  return z;
      3'b101:  return !z;
      3'b110:  return l;
      3'b111:  return !l;
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_branches = 0;
    m_mispred  = 0;
  endtask

  // Apply one cycle of inputs, check combinational outputs against the model,
  // then clock it and advance the model. Entered and left at posedge+1.
  task automatic step(input bit v, input logic [31:0] pc, input logic [2:0] code,
                      input bit z, input bit l, input bit p, input logic [31:0] ipc);
    bit t, exp_a, exp_b, exp_m;
    ex_valid = v; ex_pc = pc; ex_branch = code; ex_zero = z; ex_less = l;
    ex_pred_taken = p; if_pc = ipc;
    t     = outcome(code, z, l);
    exp_a = v && ((code == 3'b001) || (code == 3'b010) || (is_cond(code) && t));
    exp_b = v && (code == 3'b010);
    exp_m = v && is_cond(code) && (t != p);
    #3;
    check("if_pred_taken", 64'(pred), 64'(m_bht[idx_of(ipc)] >= 2));
    check("pc_src_a", 64'(src_a), 64'(exp_a));
    check("pc_src_b", 64'(src_b), 64'(exp_b));
    check("mispredict", 64'(mis), 64'(exp_m));
    check("perf_branches", 64'(perf_b), 64'(m_branches));
    check("perf_mispred", 64'(perf_m), 64'(m_mispred));
    check("perf_branches_w4", 64'(perf_b4), 64'(sat(m_branches, 15)));
    check("perf_mispred_w4", 64'(perf_m4), 64'(sat(m_mispred, 15)));
    @(posedge clk);
    if (v && is_cond(code)) begin
      int k = idx_of(pc);
      m_bht[k] = t ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3) : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
      m_branches++;
      if (exp_m) m_mispred++;
    end
    #1;
  endtask

  task automatic do_reset(input bit v, input logic [31:0] pc, input logic [2:0] code,
                          input bit z);
    rst_n = 1'b0;
    ex_valid = v; ex_pc = pc; ex_branch = code; ex_zero = z; ex_less = 1'b0;
    ex_pred_taken = 1'b0; if_pc = pc;
    @(posedge clk);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit v; logic [2:0] code; bit z; bit l; bit p;
    bit a; bit b; bit m;
  } vec_t;

  vec_t vecs [15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1, 3'b000, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 3'b001, 0, 0, 1, 1, 0, 0};
    vecs[2]  = '{1, 3'b010, 1, 1, 0, 1, 1, 0};
    vecs[3]  = '{1, 3'b011, 1, 0, 1, 0, 0, 0};
    vecs[4]  = '{1, 3'b100, 1, 0, 0, 1, 0, 1};
    vecs[5]  = '{1, 3'b100, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 3'b101, 0, 0, 1, 1, 0, 0};
    vecs[7]  = '{1, 3'b101, 1, 0, 1, 0, 0, 1};
    vecs[8]  = '{1, 3'b110, 0, 1, 1, 1, 0, 0};
    vecs[9]  = '{1, 3'b110, 0, 0, 1, 0, 0, 1};
    vecs[10] = '{1, 3'b111, 0, 0, 0, 1, 0, 1};
    vecs[11] = '{1, 3'b111, 1, 1, 0, 0, 0, 0};
    vecs[12] = '{0, 3'b001, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 3'b010, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{0, 3'b100, 1, 0, 0, 0, 0, 0};

    rst_n = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_branch = '0;
    ex_zero = 1'b0; ex_less = 1'b0; ex_pred_taken = 1'b0; if_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0, 32'h0, 3'b000, 1'b0);

    // Post-reset sweep: every entry weakly not-taken, counters cleared.
    for (int a = 0; a < 'h100; a += 4) begin
      step(0, 32'h0, 3'b000, 0, 0, 0, 32'(a));
      check("sweep_pred0", 64'(pred), 64'h0);
    end
    check("reset_perf_b", 64'(perf_b), 64'h0);
    check("reset_perf_m", 64'(perf_m), 64'h0);

    // Three taken beq at 0x40 predicted not-taken: 01 -> 10 -> 11 -> 11.
    for (int c = 0; c < 3; c++) begin
      ex_valid = 1; ex_pc = 32'h40; ex_branch = 3'b100; ex_zero = 1; ex_pred_taken = 0;
      #2;
      if (c == 0) begin
        check("beq_c1_mispredict", 64'(mis), 64'h1);
        check("beq_c1_src_a", 64'(src_a), 64'h1);
      end
      #1;
      step(1, 32'h40, 3'b100, 1, 0, 0, 32'h40);
      // step re-waits its own settle time, so re-alignment is preserved
    end
    step(0, 32'h0, 3'b000, 0, 0, 0, 32'h40);
    check("trained_pred", 64'(pred), 64'h1);
    check("trained_perf_b", 64'(perf_b), 64'd3);
    check("trained_perf_m", 64'(perf_m), 64'd3);

    // Alias 0x140 onto 0x40: two decrements, lookup lags the write by one cycle.
    step(1, 32'h140, 3'b100, 0, 0, 1, 32'h40);      // 11 -> 10
    ex_valid = 1; ex_pc = 32'h140; ex_branch = 3'b100; ex_zero = 0;
    ex_pred_taken = 1; if_pc = 32'h40;
    #2;
    check("alias_same_cycle_old", 64'(pred), 64'h1);
    #1;
    step(1, 32'h140, 3'b100, 0, 0, 1, 32'h40);      // 10 -> 01
    step(0, 32'h0, 3'b000, 0, 0, 0, 32'h40);
    check("alias_next_cycle_new", 64'(pred), 64'h0);

    // Vector table: every code, ex_valid gating.
    for (int i = 0; i < 15; i++) begin
      logic [31:0] pc;
      pc = {$urandom_range(0, 255), 2'b00};
      ex_valid = vecs[i].v; ex_pc = pc; ex_branch = vecs[i].code; ex_zero = vecs[i].z;
      ex_less = vecs[i].l; ex_pred_taken = vecs[i].p; if_pc = pc;
      #2;
      check($sformatf("vec%0d_a", i), 64'(src_a), 64'(vecs[i].a));
      check($sformatf("vec%0d_b", i), 64'(src_b), 64'(vecs[i].b));
      check($sformatf("vec%0d_m", i), 64'(mis), 64'(vecs[i].m));
      #1;
      step(vecs[i].v, pc, vecs[i].code, vecs[i].z, vecs[i].l, vecs[i].p, pc);
    end

    // Narrow counters saturate at 4'hF.
    do_reset(1'b0, 32'h0, 3'b000, 1'b0);
    for (int i = 0; i < 20; i++) step(1, 32'h80, 3'b101, 0, 0, 0, 32'h80);
    step(0, 32'h0, 3'b000, 0, 0, 0, 32'h0);
    check("sat4_branches", 64'(perf_b4), 64'hF);
    check("sat4_mispred", 64'(perf_m4), 64'hF);
    check("wide_branches", 64'(perf_b), 64'd20);

    // Reset wins over a simultaneous taken update.
    for (int i = 0; i < 3; i++) step(1, 32'h40, 3'b100, 1, 0, 1, 32'h40);
    do_reset(1'b1, 32'h40, 3'b100, 1'b1);
    step(0, 32'h0, 3'b000, 0, 0, 0, 32'h40);
    check("rst_prio_pred", 64'(pred), 64'h0);
    check("rst_prio_perf_b", 64'(perf_b), 64'h0);
    check("rst_prio_perf_m", 64'(perf_m), 64'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc, ipc;
      pc  = ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 127), 2'b00};
      ipc = ($urandom_range(0, 1) == 0) ? pc : {$urandom_range(0, 127), 2'b00};
      step(1'($urandom_range(0, 4) != 0), pc, 3'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), ipc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
